// File: rtl/uart_rdata_sender_pkg.sv
// Shared definitions for the monitor dump line sender: FSM states,
// line-terminator/separator characters and line lengths.
package uart_rdata_sender_pkg;

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_HEX0 = 3'd1,
    S_SEP  = 3'd2,
    S_HEX1 = 3'd3,
    S_CR   = 3'd4,
    S_LF   = 3'd5,
    S_DONE = 3'd6
  } state_e;

  localparam logic [7:0] CHAR_CR    = 8'h0d;
  localparam logic [7:0] CHAR_LF    = 8'h0a;
  localparam logic [7:0] CHAR_SPACE = 8'h20;

  localparam int LINE_LEN_FULL = 19;
  localparam int LINE_LEN_PC   = 10;

  localparam logic [3:0] LAST_NIB = 4'd7;

endpackage

// File: rtl/uart_rdata_sender_if.sv
// Byte stream handshake between the dump sender and the UART transmitter.
interface uart_rdata_sender_if;
  logic       tx_valid;
  logic [7:0] tx_data;
  logic       tx_ready;

  modport master (output tx_valid, output tx_data, input tx_ready);
  modport slave  (input tx_valid, input tx_data, output tx_ready);
endinterface

// File: rtl/uart_rdata_sender_hex_char.sv
// Combinational nibble to ASCII hex digit, upper or lower case letters.
module uart_rdata_sender_hex_char #(
  parameter bit UPPER_HEX = 1'b1
) (
  input  logic [3:0] nibble_i,
  output logic [7:0] char_o
);

  // Letter base is offset by 10 so the nibble can be added directly.
  always_comb begin
    if (nibble_i < 4'd10) char_o = 8'h30 + {4'h0, nibble_i};
    else                  char_o = (UPPER_HEX ? 8'h37 : 8'h57) + {4'h0, nibble_i};
  end

endmodule

// File: rtl/uart_rdata_sender.sv
// Streams a captured 64-bit dump word to the UART as an ASCII hex line
// ending in CR LF, then pulses flushing_wq to advance the dump sequencer.
module uart_rdata_sender import uart_rdata_sender_pkg::*; #(
  parameter bit         UPPER_HEX = 1'b1,
  parameter logic [7:0] SEP_CHAR  = CHAR_SPACE,
  parameter logic [7:0] CR_CHAR   = CHAR_CR,
  parameter logic [7:0] LF_CHAR   = CHAR_LF
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       rdata_snd_start,
  input  logic [63:0]                rdata_snd,
  input  logic                       pc_print_sel,
  input  logic                       snd_abort,
  uart_rdata_sender_if.master        tx,
  output logic                       flushing_wq,
  output logic                       snd_busy
);

  state_e      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [63:0] shad_data_q, shad_data_d;
  logic        shad_pc_q, shad_pc_d;
  logic        tx_valid_q, tx_valid_d;
  logic [7:0]  tx_data_q, tx_data_d;
  logic        flush_q, flush_d;
  logic        busy_q, busy_d;

  logic        xfer;
  logic [31:0] word_d;
  logic [3:0]  nibble_d;
  logic [7:0]  hex_ch;

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    shad_data_d = shad_data_q;
    shad_pc_d   = shad_pc_q;
    xfer        = tx_valid_q & tx.tx_ready;

    case (state_q)
      S_IDLE: begin
        if (rdata_snd_start && !snd_abort) begin
          shad_data_d = rdata_snd;
          shad_pc_d   = pc_print_sel;
          state_d     = S_HEX0;
          cnt_d       = 4'd0;
        end
      end
      S_HEX0: begin
        if (xfer) begin
          if (cnt_q == LAST_NIB) begin
            state_d = shad_pc_q ? S_CR : S_SEP;
            cnt_d   = 4'd0;
          end else begin
            cnt_d = cnt_q + 4'd1;
          end
        end
      end
      S_SEP: begin
        if (xfer) begin
          state_d = S_HEX1;
          cnt_d   = 4'd0;
        end
      end
      S_HEX1: begin
        if (xfer) begin
          if (cnt_q == LAST_NIB) begin
            state_d = S_CR;
            cnt_d   = 4'd0;
          end else begin
            cnt_d = cnt_q + 4'd1;
          end
        end
      end
      S_CR:    if (xfer) state_d = S_LF;
      S_LF:    if (xfer) state_d = S_DONE;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    if (snd_abort && state_q != S_IDLE) begin
      state_d = S_IDLE;
      cnt_d   = 4'd0;
    end
  end

  // Outputs are registered, so the next character is formed from next-state values.
  assign word_d   = (state_d == S_HEX1) ? shad_data_d[63:32] : shad_data_d[31:0];
  assign nibble_d = word_d[{~cnt_d[2:0], 2'b00} +: 4];

  uart_rdata_sender_hex_char #(
    .UPPER_HEX (UPPER_HEX)
  ) u_hex_char (
    .nibble_i (nibble_d),
    .char_o   (hex_ch)
  );

  always_comb begin
    case (state_d)
      S_HEX0, S_HEX1: tx_data_d = hex_ch;
      S_SEP:          tx_data_d = SEP_CHAR;
      S_CR:           tx_data_d = CR_CHAR;
      S_LF:           tx_data_d = LF_CHAR;
      default:        tx_data_d = 8'h00;
    endcase
    tx_valid_d = (state_d inside {S_HEX0, S_SEP, S_HEX1, S_CR, S_LF});
    flush_d    = (state_d == S_DONE);
    busy_d     = (state_d != S_IDLE);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      cnt_q       <= 4'd0;
      shad_data_q <= 64'd0;
      shad_pc_q   <= 1'b0;
      tx_valid_q  <= 1'b0;
      tx_data_q   <= 8'h00;
      flush_q     <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      shad_data_q <= shad_data_d;
      shad_pc_q   <= shad_pc_d;
      tx_valid_q  <= tx_valid_d;
      tx_data_q   <= tx_data_d;
      flush_q     <= flush_d;
      busy_q      <= busy_d;
    end
  end

  assign tx.tx_valid = tx_valid_q;
  assign tx.tx_data  = tx_data_q;
  assign flushing_wq = flush_q;
  assign snd_busy    = busy_q;

endmodule

// File: tb/tb_uart_rdata_sender.sv
// Directed bench for uart_rdata_sender: upper- and lower-case instances share stimulus.
module tb_uart_rdata_sender;

  logic        clk = 1'b0;
  logic        rst_n, start, pc_sel, abort, rdy;
  logic [63:0] rdata;
  logic        flush_u, busy_u, flush_l, busy_l;

  always #5 clk = ~clk;

  uart_rdata_sender_if if_u ();
  uart_rdata_sender_if if_l ();
  assign if_u.tx_ready = rdy;
  assign if_l.tx_ready = rdy;

  uart_rdata_sender #(.UPPER_HEX(1'b1)) dut_u (
    .clk(clk), .rst_n(rst_n), .rdata_snd_start(start), .rdata_snd(rdata),
    .pc_print_sel(pc_sel), .snd_abort(abort), .tx(if_u),
    .flushing_wq(flush_u), .snd_busy(busy_u)
  );

  uart_rdata_sender #(.UPPER_HEX(1'b0)) dut_l (
    .clk(clk), .rst_n(rst_n), .rdata_snd_start(start), .rdata_snd(rdata),
    .pc_print_sel(pc_sel), .snd_abort(abort), .tx(if_l),
    .flushing_wq(flush_l), .snd_busy(busy_l)
  );

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  logic [7:0] q_u[$];
  logic [7:0] q_l[$];
  int         qc_u[$];
  int         f_u = 0, f_l = 0, fcyc_u = 0, cyc = 0;
  logic       prev_stall = 1'b0;
  logic [7:0] prev_data = 8'h00;

  // Inputs change just after the rising edge, so negedge values are what the next edge sees.
  always @(negedge clk) begin
    cyc++;
    if (prev_stall) begin
      check("hold_valid", if_u.tx_valid, 1'b1);
      check("hold_data", if_u.tx_data, prev_data);
    end
    prev_stall = rst_n & if_u.tx_valid & ~rdy & ~abort;
    prev_data  = if_u.tx_data;
    if (rst_n && if_u.tx_valid && rdy) begin
      q_u.push_back(if_u.tx_data);
      qc_u.push_back(cyc);
    end
    if (rst_n && if_l.tx_valid && rdy) q_l.push_back(if_l.tx_data);
    if (flush_u) begin
      f_u++;
      fcyc_u = cyc;
    end
    if (flush_l) f_l++;
  end

  task automatic do_start(input logic [63:0] d, input logic pc);
    @(posedge clk); #1;
    q_u.delete(); q_l.delete(); qc_u.delete();
    start = 1'b1; rdata = d; pc_sel = pc;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic wait_idle(input int mode, input int maxc);
    bit done;
    done = 1'b0;
    for (int i = 0; i < maxc && !done; i++) begin
      @(posedge clk); #1;
      rdy = (mode == 1) ? ((i % 4 == 0) || (i % 4 == 3)) : 1'b1;
      if (!busy_u) done = 1'b1;
    end
    rdy = 1'b1;
    check("idle_timeout", done, 1'b1);
  endtask

  task automatic check_line(input string tag, input bit lower, input string exp);
    int         n;
    logic [7:0] b, e;
    n = lower ? q_l.size() : q_u.size();
    check({tag, "_len"}, n, exp.len());
    for (int i = 0; i < exp.len(); i++) begin
      b = lower ? q_l[i] : q_u[i];
      e = exp[i];
      check($sformatf("%s_b%0d", tag, i), b, e);
    end
  endtask

  int f0, fl0;

  initial begin
    rst_n = 1'b0; start = 1'b0; pc_sel = 1'b0; abort = 1'b0; rdy = 1'b1; rdata = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_valid", if_u.tx_valid, 1'b0);
    check("rst_data", if_u.tx_data, 8'h00);
    check("rst_flush", flush_u, 1'b0);
    check("rst_busy", busy_u, 1'b0);
    @(posedge clk); #1;
    rst_n = 1'b1;

    // Full line, TX always ready
    f0 = f_u;
    do_start(64'h89ABCDEF_01234567, 1'b0);
    @(negedge clk);
    check("lat_valid", if_u.tx_valid, 1'b1);
    check("lat_data", if_u.tx_data, 8'h30);
    check("lat_busy", busy_u, 1'b1);
    wait_idle(0, 60);
    check_line("full", 1'b0, "01234567 89ABCDEF\015\012");
    check("full_flush", f_u - f0, 1);
    check("full_gap", qc_u[qc_u.size()-1] - qc_u[0], 18);
    check("full_flush_at", fcyc_u - qc_u[qc_u.size()-1], 1);

    // pc mode, both letter cases
    f0 = f_u; fl0 = f_l;
    do_start({32'hFFFF_FFFF, 32'h0000_1a2c}, 1'b1);
    wait_idle(0, 60);
    check_line("pc_up", 1'b0, "00001A2C\015\012");
    check_line("pc_lo", 1'b1, "00001a2c\015\012");
    check("pc_flush_u", f_u - f0, 1);
    check("pc_flush_l", f_l - fl0, 1);

    // Backpressure 1,0,0,1
    f0 = f_u;
    do_start(64'h0F1E2D3C_4B5A6978, 1'b0);
    wait_idle(1, 200);
    check_line("bp", 1'b0, "4B5A6978 0F1E2D3C\015\012");
    check("bp_flush", f_u - f0, 1);

    // Starts while busy (5th byte cycle and S_DONE) are dropped
    f0 = f_u;
    do_start(64'h11223344_55667788, 1'b0);
    repeat (4) @(posedge clk); #1;
    start = 1'b1; rdata = 64'hDEADBEEF_CAFEF00D; pc_sel = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (14) @(posedge clk); #1;
    start = 1'b1;
    @(negedge clk);
    check("busy_done_flush", flush_u, 1'b1);
    @(posedge clk); #1;
    start = 1'b0;
    repeat (3) @(posedge clk); #1;
    check("busy_not_queued", busy_u, 1'b0);
    check("busy_no_valid", if_u.tx_valid, 1'b0);
    check_line("busy", 1'b0, "55667788 11223344\015\012");
    check("busy_flush", f_u - f0, 1);

    // Abort beats start in idle
    @(posedge clk); #1;
    start = 1'b1; abort = 1'b1;
    @(posedge clk); #1;
    start = 1'b0; abort = 1'b0;
    check("prio_busy", busy_u, 1'b0);

    // Abort on byte 6
    f0 = f_u;
    do_start(64'hA5A5A5A5_76543210, 1'b0);
    repeat (5) @(posedge clk); #1;
    abort = 1'b1;
    @(posedge clk); #1;
    abort = 1'b0;
    check("abort_valid", if_u.tx_valid, 1'b0);
    check("abort_busy", busy_u, 1'b0);
    check("abort_flush", flush_u, 1'b0);
    repeat (4) @(posedge clk); #1;
    check_line("abort", 1'b0, "765432");
    check("abort_no_flush", f_u - f0, 0);
    do_start(64'hFEDCBA98_76543210, 1'b0);
    wait_idle(0, 60);
    check_line("after_abort", 1'b0, "76543210 FEDCBA98\015\012");
    check("after_abort_flush", f_u - f0, 1);

    // Reset during S_HEX1
    f0 = f_u;
    do_start(64'h13579BDF_2468ACE0, 1'b0);
    repeat (11) @(posedge clk); #1;
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    check("mrst_valid", if_u.tx_valid, 1'b0);
    check("mrst_data", if_u.tx_data, 8'h00);
    check("mrst_flush", flush_u, 1'b0);
    check("mrst_busy", busy_u, 1'b0);
    repeat (4) @(posedge clk); #1;
    check("mrst_no_flush", f_u - f0, 0);
    do_start(64'h0BADF00D_C0FFEE11, 1'b0);
    wait_idle(0, 60);
    check_line("after_rst", 1'b0, "C0FFEE11 0BADF00D\015\012");
    check("after_rst_flush", f_u - f0, 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

endmodule
